e203_tohost_mbox: RTL and testbench

- Memory-mapped ICB slave that the core under test writes its test result to ("tohost" mailbox). It is the responder end of the pass/fail reporting protocol.
- Captures the result and freezes cycle and committed-instruction counters at test end. Raises sticky done/pass/fail flags for the bench and for on-chip status pins.
- Sits on the E203 private peripheral ICB bus, beside the CLINT/PLIC, clocked from hfclk.

---
 rtl/e203_tohost_mbox.sv | 122 ++++++++++++
 tb/tb_e203_tohost_mbox.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/e203_tohost_mbox.sv
// e203_tohost_mbox: ICB "tohost" mailbox that captures the test result, freezes the
// cycle/instruction counters at test end and raises sticky done/pass/fail flags.
// Optional watchdog: define E203_TOHOST_TIMEOUT_EN to fail the test after TIMEOUT_CYC cycles.
module e203_tohost_mbox #(
    parameter int          AW          = 12,
    parameter int          CNT_W       = 32,
    parameter logic [31:0] TIMEOUT_CYC = 32'd10000000
) (
    input  logic          hfclk,
    input  logic          rst_n,
    input  logic          icb_cmd_valid,
    output logic          icb_cmd_ready,
    input  logic [AW-1:0] icb_cmd_addr,
    input  logic          icb_cmd_read,
    input  logic [31:0]   icb_cmd_wdata,
    input  logic [3:0]    icb_cmd_wmask,
    output logic          icb_rsp_valid,
    input  logic          icb_rsp_ready,
    output logic [31:0]   icb_rsp_rdata,
    output logic          icb_rsp_err,
    input  logic          cmt_valid,
    output logic          test_done,
    output logic          test_pass,
    output logic          test_fail
);
    localparam int IW = AW - 2;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state;
    logic [31:0]      tohost;
    logic [CNT_W-1:0] cyc_cnt, ins_cnt, wr_cnt, cyc_nxt;
    logic             timeout;
    logic [IW-1:0]    idx;
    logic             cmd_hs, wr, err, wr_ok, term, cyc_inc, ins_inc, tmo_hit;
    logic [31:0]      rdata;
    logic             unused_bits;

    assign icb_cmd_ready = ~icb_rsp_valid | icb_rsp_ready;
    assign cmd_hs        = icb_cmd_valid & icb_cmd_ready;
    assign idx           = icb_cmd_addr[AW-1:2];

    // Decode the command, classify errors, pick read data and the counter/terminate conditions
    always_comb begin
        wr      = ~icb_cmd_read;
        err     = (idx > IW'(4)) | (wr & ((idx != '0) | (icb_cmd_wmask != 4'hF)));
        rdata   = (err | wr)      ? 32'h0 :
                  (idx == IW'(0)) ? tohost :
                  (idx == IW'(1)) ? 32'(cyc_cnt) :
                  (idx == IW'(2)) ? 32'(ins_cnt) :
                  (idx == IW'(3)) ? {28'h0, timeout, test_fail, test_pass, test_done} :
                                    32'(wr_cnt);
        wr_ok   = cmd_hs & wr & ~err;
        term    = wr_ok & icb_cmd_wdata[0] & (state == RUN);
        cyc_inc = (state == RUN) | ((state == IDLE) & cmt_valid);
        ins_inc = cmt_valid & (state != DONE);
        cyc_nxt = (cyc_inc && !(&cyc_cnt)) ? cyc_cnt + CNT_W'(1) : cyc_cnt;
`ifdef E203_TOHOST_TIMEOUT_EN
        tmo_hit = (state == RUN) & (cyc_nxt == CNT_W'(TIMEOUT_CYC)) & ~term;
`else
        tmo_hit = 1'b0;
`endif
    end

`ifdef E203_TOHOST_TIMEOUT_EN
    assign unused_bits = ^icb_cmd_addr[1:0];
`else
    assign unused_bits = ^{icb_cmd_addr[1:0], TIMEOUT_CYC};
`endif

    // Test-state FSM with the stored result and sticky flags; the result freezes once DONE
    always_ff @(posedge hfclk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tohost    <= 32'h0;
            test_done <= 1'b0;
            test_pass <= 1'b0;
            test_fail <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            if (wr_ok && state != DONE) tohost <= icb_cmd_wdata;
            if (state == IDLE && cmt_valid) state <= RUN;
            if (term) begin
                state     <= DONE;
                test_done <= 1'b1;
                test_pass <= (icb_cmd_wdata == 32'h1);
                test_fail <= (icb_cmd_wdata != 32'h1);
            end else if (tmo_hit) begin
                state     <= DONE;
                test_done <= 1'b1;
                test_fail <= 1'b1;
                timeout   <= 1'b1;
            end
        end
    end

    // Saturating counters: cycles in RUN, commits until DONE, every accepted TOHOST write
    always_ff @(posedge hfclk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_cnt <= '0;
            ins_cnt <= '0;
            wr_cnt  <= '0;
        end else begin
            cyc_cnt <= cyc_nxt;
            ins_cnt <= (ins_inc && !(&ins_cnt)) ? ins_cnt + CNT_W'(1) : ins_cnt;
            wr_cnt  <= (wr_ok && !(&wr_cnt)) ? wr_cnt + CNT_W'(1) : wr_cnt;
        end
    end

    // Single-entry response register, held stable until the master takes it
    always_ff @(posedge hfclk or negedge rst_n) begin
        if (!rst_n) begin
            icb_rsp_valid <= 1'b0;
            icb_rsp_rdata <= 32'h0;
            icb_rsp_err   <= 1'b0;
        end else if (cmd_hs) begin
            icb_rsp_valid <= 1'b1;
            icb_rsp_rdata <= rdata;
            icb_rsp_err   <= err;
        end else if (icb_rsp_ready) begin
            icb_rsp_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_e203_tohost_mbox.sv
// tb_e203_tohost_mbox: scoreboard bench for the tohost mailbox; responses are checked
// by a monitor process against expectations queued when each command is issued.
module tb_e203_tohost_mbox;
    logic        hfclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        icb_cmd_valid = 1'b0;
    logic        icb_cmd_ready;
    logic [11:0] icb_cmd_addr = '0;
    logic        icb_cmd_read = 1'b0;
    logic [31:0] icb_cmd_wdata = '0;
    logic [3:0]  icb_cmd_wmask = '0;
    logic        icb_rsp_valid;
    logic        icb_rsp_ready = 1'b1;
    logic [31:0] icb_rsp_rdata;
    logic        icb_rsp_err;
    logic        cmt_valid = 1'b0;
    logic        test_done, test_pass, test_fail;

    typedef struct {
        logic [32:0] v;
        string       nm;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;
    exp_t stim_e;
    int   n_chk = 0;
    int   n_fail = 0;
    int   wt;

    always #5 hfclk = ~hfclk;

    e203_tohost_mbox #(.AW(12), .CNT_W(32), .TIMEOUT_CYC(32'd100)) dut (
        .hfclk(hfclk), .rst_n(rst_n),
        .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready),
        .icb_cmd_addr(icb_cmd_addr), .icb_cmd_read(icb_cmd_read),
        .icb_cmd_wdata(icb_cmd_wdata), .icb_cmd_wmask(icb_cmd_wmask),
        .icb_rsp_valid(icb_rsp_valid), .icb_rsp_ready(icb_rsp_ready),
        .icb_rsp_rdata(icb_rsp_rdata), .icb_rsp_err(icb_rsp_err),
        .cmt_valid(cmt_valid),
        .test_done(test_done), .test_pass(test_pass), .test_fail(test_fail)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_flags(input string nm, input logic d, input logic p, input logic f);
        check(nm, 64'({test_done, test_pass, test_fail}), 64'({d, p, f}));
    endtask

    // Monitor: every response the master accepts is compared with the oldest expectation
    always begin
        @(negedge hfclk);
        #2;
        if (icb_rsp_valid === 1'b1 && icb_rsp_ready) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_rsp: got err=%0b rdata=%0h, expected no response", icb_rsp_err, icb_rsp_rdata);
            end else begin
                mon_e = sb.pop_front();
                check(mon_e.nm, 64'({icb_rsp_err, icb_rsp_rdata}), 64'(mon_e.v));
            end
        end
    end

    task automatic xact(input bit is_rd, input logic [11:0] a, input logic [31:0] wd, input logic [3:0] wm,
                        input logic [31:0] erd, input bit eerr, input string nm, input bit push);
        int n = 0;
        if (push) begin
            stim_e.v  = {eerr, erd};
            stim_e.nm = nm;
            sb.push_back(stim_e);
        end
        icb_cmd_valid = 1'b1;
        icb_cmd_read  = is_rd;
        icb_cmd_addr  = a;
        icb_cmd_wdata = wd;
        icb_cmd_wmask = wm;
        while (!icb_cmd_ready && n < 50) begin
            @(negedge hfclk);
            n++;
        end
        if (!icb_cmd_ready) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: cmd_ready stayed 0 for %0d cycles, expected 1", nm, n);
        end
        @(negedge hfclk);
        icb_cmd_valid = 1'b0;
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] e, input bit ee, input string nm);
        xact(1'b1, a, 32'h0, 4'h0, e, ee, nm, 1'b1);
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] m, input bit ee, input string nm);
        xact(1'b0, a, d, m, 32'h0, ee, nm, 1'b1);
    endtask

    task automatic commits(input int n);
        for (int i = 0; i < n; i++) begin
            cmt_valid = 1'b1;
            @(negedge hfclk);
        end
        cmt_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge hfclk);
        rst_n         = 1'b0;
        icb_cmd_valid = 1'b0;
        cmt_valid     = 1'b0;
        icb_rsp_ready = 1'b1;
        repeat (2) @(negedge hfclk);
        rst_n = 1'b1;
        @(negedge hfclk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "global timeout");
    end

    initial begin
        // Reset state, then pass after 5 commits
        do_reset();
        check("rst_outputs", 64'({icb_rsp_valid, icb_rsp_err, icb_rsp_rdata, icb_cmd_ready}), 64'({1'b0, 1'b0, 32'h0, 1'b1}));
        chk_flags("rst_flags", 0, 0, 0);
        rd(12'h00C, 32'h0, 0, "rst_status");
        rd(12'h004, 32'h0, 0, "rst_cycle");
        rd(12'h010, 32'h0, 0, "rst_wcnt");
        commits(5);
        chk_flags("pre_pass_flags", 0, 0, 0);
        wr(12'h000, 32'h1, 4'hF, 0, "wr_pass");
        chk_flags("pass_flags", 1, 1, 0);
        rd(12'h008, 32'd5, 0, "instr_pass");
        rd(12'h00C, 32'h3, 0, "status_pass");
        rd(12'h004, 32'd6, 0, "cycle_frozen");
        rd(12'h000, 32'h1, 0, "tohost_pass");
        rd(12'h011, 32'd1, 0, "wcnt_pass_addr_lsb_ignored");
        repeat (5) @(negedge hfclk);
        rd(12'h004, 32'd6, 0, "cycle_later");

        // Non-terminating write: counters keep running
        do_reset();
        commits(2);
        wr(12'h000, 32'h4, 4'hF, 0, "wr_nonterm");
        chk_flags("nonterm_flags", 0, 0, 0);
        rd(12'h010, 32'd1, 0, "wcnt_nonterm");
        rd(12'h004, 32'd4, 0, "cycle_run1");
        rd(12'h004, 32'd5, 0, "cycle_run2");
        rd(12'h000, 32'h4, 0, "tohost_nonterm");
        rd(12'h008, 32'd2, 0, "instr_run");
        wr(12'h000, 32'h1, 4'h3, 1, "err_wmask_run");
        chk_flags("flags_after_err_run", 0, 0, 0);
        rd(12'h010, 32'd1, 0, "wcnt_after_err_run");

        // Fail result, sticky across later writes, and error responses in DONE
        do_reset();
        commits(1);
        wr(12'h000, 32'h7, 4'hF, 0, "wr_fail");
        chk_flags("fail_flags", 1, 0, 1);
        rd(12'h00C, 32'h5, 0, "status_fail");
        rd(12'h000, 32'h7, 0, "tohost_fail");
        wr(12'h000, 32'h1, 4'hF, 0, "wr_after_done");
        chk_flags("sticky_flags", 1, 0, 1);
        rd(12'h010, 32'd2, 0, "wcnt_after_done");
        rd(12'h000, 32'h7, 0, "tohost_sticky");
        wr(12'h004, 32'hFF, 4'hF, 1, "err_wr_ro");
        wr(12'h020, 32'h1, 4'hF, 1, "err_unmapped_wr");
        wr(12'h000, 32'h1, 4'h3, 1, "err_wmask");
        rd(12'h014, 32'h0, 1, "err_unmapped_rd");
        rd(12'h004, 32'd2, 0, "cycle_after_err");
        rd(12'h010, 32'd2, 0, "wcnt_after_err");
        chk_flags("flags_after_err", 1, 0, 1);

        // Response backpressure: response held, next command blocked
        @(negedge hfclk);
        icb_rsp_ready = 1'b0;
        rd(12'h00C, 32'h5, 0, "stall_status");
        stim_e.v  = {1'b0, 32'd2};
        stim_e.nm = "stall_second_wcnt";
        sb.push_back(stim_e);
        icb_cmd_valid = 1'b1;
        icb_cmd_read  = 1'b1;
        icb_cmd_addr  = 12'h010;
        repeat (3) begin
            check("stall_rsp_valid", 64'(icb_rsp_valid), 64'd1);
            check("stall_rsp_data", 64'({icb_rsp_err, icb_rsp_rdata}), 64'({1'b0, 32'h5}));
            check("stall_cmd_ready", 64'(icb_cmd_ready), 64'd0);
            @(negedge hfclk);
        end
        icb_rsp_ready = 1'b1;
        @(negedge hfclk);
        icb_cmd_valid = 1'b0;

        // Reset while a response is pending drops it at once
        @(negedge hfclk);
        icb_rsp_ready = 1'b0;
        xact(1'b1, 12'h00C, 32'h0, 4'h0, 32'h0, 0, "dropped", 1'b0);
        rst_n = 1'b0;
        #1;
        check("rst_drop_rsp_valid", 64'(icb_rsp_valid), 64'd0);
        chk_flags("rst_mid_flags", 0, 0, 0);
        icb_rsp_ready = 1'b1;
        @(negedge hfclk);
        rst_n = 1'b1;
        @(negedge hfclk);
        rd(12'h00C, 32'h0, 0, "status_after_rst");

        // Watchdog
        do_reset();
        commits(1);
`ifdef E203_TOHOST_TIMEOUT_EN
        wt = 0;
        while (!test_done && wt < 200) begin
            @(negedge hfclk);
            wt++;
        end
        chk_flags("timeout_flags", 1, 0, 1);
        rd(12'h00C, 32'hD, 0, "status_timeout");
        rd(12'h004, 32'd100, 0, "cycle_timeout");
        rd(12'h000, 32'h0, 0, "tohost_timeout");
`else
        repeat (150) @(negedge hfclk);
        chk_flags("no_watchdog_flags", 0, 0, 0);
        rd(12'h00C, 32'h0, 0, "status_no_watchdog");
`endif

        wt = 0;
        while (sb.size() != 0 && wt < 20) begin
            @(negedge hfclk);
            wt++;
        end
        if (sb.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d responses outstanding, expected 0", sb.size());
        end
        repeat (2) @(negedge hfclk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
